// File: rtl/uart_program_loader.sv
// uart_program_loader: parses framed UART bytes into 32-bit memory writes and releases the core on a good checksum.
// Optional status echo on the UART transmitter when UART_LOADER_ECHO_EN is defined.
module uart_program_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned MAX_LEN_WORDS  = 16384
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Mem_Req,
   output logic [31:0] o_Mem_Addr,
   output logic [31:0] o_Mem_Data,
   input  logic        i_Mem_Ack,
   output logic        o_Core_Reset,
   output logic        o_Busy,
   output logic        o_Error
`ifdef UART_LOADER_ECHO_EN
   ,
   output logic        o_Tx_Start,
   output logic [7:0]  o_Tx_Byte
`endif
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CSUM, DONE, ERROR} state_t;
   state_t        state, state_nxt;
   logic [TW-1:0] timer;
   logic [1:0]    byte_cnt;
   logic [31:0]   addr, len, data, addr_full, len_full;
   logic [7:0]    csum, skid_byte, byte_d;
   logic          skid_v, overrun, byte_v, last_byte, counting, timeout;
   // A byte parked in the skid buffer takes precedence over the live receiver byte.
   always_comb begin
      byte_v    = state != WRITE && (skid_v || i_Rx_DV);
      byte_d    = skid_v ? skid_byte : i_Rx_Byte;
      last_byte = byte_v && byte_cnt == 2'd3;
      addr_full = {byte_d, addr[31:8]};
      len_full  = {byte_d, len[31:8]};
      counting  = state inside {ADDR, LEN, DATA, CSUM};
      timeout   = counting && !byte_v && timer == TW'(TIMEOUT_CYCLES - 1);
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ERROR: if (byte_v && byte_d == 8'hA5) state_nxt = ADDR;
         ADDR:  if (last_byte) state_nxt = addr_full[1:0] != 2'd0 ? ERROR : LEN;
         LEN:   if (last_byte) state_nxt = len_full > 32'(MAX_LEN_WORDS) ? ERROR : (len_full == 32'd0 ? CSUM : DATA);
         DATA:  if (last_byte) state_nxt = WRITE;
         WRITE: if (i_Mem_Ack) state_nxt = (overrun || (i_Rx_DV && skid_v)) ? ERROR : (len == 32'd1 ? CSUM : DATA);
         CSUM:  if (byte_v) state_nxt = byte_d == csum ? DONE : ERROR;
         default: state_nxt = state;
      endcase
      if (timeout) state_nxt = ERROR;
      o_Mem_Req    = state == WRITE;
      o_Mem_Addr   = addr;
      o_Mem_Data   = data;
      o_Core_Reset = state != DONE;
      o_Busy       = counting || state == WRITE;
      o_Error      = state == ERROR;
   end
   always_ff @(posedge i_Clock or posedge i_Reset)
      if (i_Reset) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge i_Clock or posedge i_Reset)
      if (i_Reset) begin
         timer     <= '0;
         byte_cnt  <= '0;
         addr      <= '0;
         len       <= '0;
         data      <= '0;
         csum      <= '0;
         skid_byte <= '0;
         skid_v    <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         timer   <= i_Rx_DV ? '0 : (counting ? timer + 1'b1 : timer);
         overrun <= state == WRITE && (overrun || (i_Rx_DV && skid_v));
         if (state_nxt == ERROR) skid_v <= 1'b0;
         else if (state == WRITE) skid_v <= skid_v || i_Rx_DV;
         else skid_v <= skid_v && i_Rx_DV;
         if (i_Rx_DV && (state == WRITE ? !skid_v : skid_v)) skid_byte <= i_Rx_Byte;
         if (byte_v && state inside {ADDR, LEN, DATA}) byte_cnt <= byte_cnt + 2'd1;
         if (byte_v && state == ADDR) addr <= addr_full;
         if (byte_v && state == LEN) len <= len_full;
         if (byte_v && state == DATA) begin
            data <= {byte_d, data[31:8]};
            csum <= csum ^ byte_d;
         end
         if (state == WRITE && i_Mem_Ack) begin
            addr <= addr + 32'd4;
            len  <= len - 32'd1;
         end
         if (state_nxt == ADDR && state != ADDR) begin
            byte_cnt <= '0;
            csum     <= '0;
         end
      end
`ifdef UART_LOADER_ECHO_EN
   always_ff @(posedge i_Clock or posedge i_Reset)
      if (i_Reset) begin
         o_Tx_Start <= 1'b0;
         o_Tx_Byte  <= 8'h00;
      end else begin
         o_Tx_Start <= state_nxt != state && (state_nxt == DONE || state_nxt == ERROR);
         if (state_nxt != state && (state_nxt == DONE || state_nxt == ERROR))
            o_Tx_Byte <= state_nxt == DONE ? 8'h4B : 8'h45;
      end
`endif
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: randomized frames against a frame-parsing reference model, plus directed boundary scenarios.
module tb_uart_program_loader;
   localparam int unsigned TO   = 100;
   localparam int unsigned MAXW = 8;
   typedef bit [63:0] wr_t;
   typedef bit [7:0] bq_t[$];
   logic        i_Clock = 1'b0;
   logic        i_Reset = 1'b0;
   logic        i_Rx_DV = 1'b0;
   logic [7:0]  i_Rx_Byte = 8'h00;
   logic        i_Mem_Ack;
   logic        o_Mem_Req, o_Core_Reset, o_Busy, o_Error;
   logic [31:0] o_Mem_Addr, o_Mem_Data;
   int  checks = 0, errors = 0, stall = -1, stab_err = 0;
   bit  req_seen = 0;
   wr_t got[$], exp_q[$];
   uart_program_loader #(.TIMEOUT_CYCLES(TO), .MAX_LEN_WORDS(MAXW)) dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
      .o_Mem_Req(o_Mem_Req), .o_Mem_Addr(o_Mem_Addr), .o_Mem_Data(o_Mem_Data), .i_Mem_Ack(i_Mem_Ack),
      .o_Core_Reset(o_Core_Reset), .o_Busy(o_Busy), .o_Error(o_Error)
   );
   always #5 i_Clock = ~i_Clock;
   // Memory responder: random or forced stall, spurious acks while idle, logs accepted writes.
   initial begin
      int wait_cnt, target;
      wr_t held;
      i_Mem_Ack = 1'b0;
      wait_cnt = 0;
      target = 0;
      forever begin
         @(negedge i_Clock);
         if (o_Mem_Req === 1'b1) begin
            req_seen = 1;
            if (wait_cnt == 0) begin
               target = stall < 0 ? int'($urandom_range(0, 5)) : stall;
               held = {o_Mem_Addr, o_Mem_Data};
            end else if ({o_Mem_Addr, o_Mem_Data} !== held) stab_err++;
            if (wait_cnt >= target) begin
               i_Mem_Ack = 1'b1;
               got.push_back({o_Mem_Addr, o_Mem_Data});
               wait_cnt = 0;
            end else begin
               i_Mem_Ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            i_Mem_Ack = $urandom_range(0, 3) == 0;
            wait_cnt = 0;
         end
      end
   end
   initial begin
      repeat (90000) @(posedge i_Clock);
      $display("FAIL watchdog: simulation exceeded 90000 cycles, required completion");
      $fatal(1);
   end
   // Reference model: returns 0 incomplete, 1 loaded, 2 frame error; fills exp_q with expected writes.
   function automatic int model(input bq_t b);
      int i = 0, p;
      bit [31:0] a, n, wd;
      bit [7:0] x = 8'h00;
      exp_q.delete();
      while (i < b.size() && b[i] != 8'hA5) i++;
      if (i + 9 > b.size()) return 0;
      a = {b[i+4], b[i+3], b[i+2], b[i+1]};
      n = {b[i+8], b[i+7], b[i+6], b[i+5]};
      if (a % 4 != 0 || n > MAXW) return 2;
      p = i + 9;
      for (int k = 0; k < int'(n); k++) begin
         if (p + 4 > b.size()) return 0;
         wd = {b[p+3], b[p+2], b[p+1], b[p]};
         exp_q.push_back({a + 32'(4 * k), wd});
         x ^= b[p] ^ b[p+1] ^ b[p+2] ^ b[p+3];
         p += 4;
      end
      return p < b.size() ? (b[p] == x ? 1 : 2) : 0;
   endfunction
   function automatic bq_t make_frame(input bit [31:0] a, input int n, input bit good);
      bq_t q;
      bit [7:0] x = 8'h00, d;
      bit [31:0] nl = 32'(n);
      q.push_back(8'hA5);
      for (int i = 0; i < 4; i++) q.push_back(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) q.push_back(nl[8*i +: 8]);
      for (int i = 0; i < 4 * n; i++) begin
         d = 8'($urandom);
         q.push_back(d);
         x ^= d;
      end
      q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
      return q;
   endfunction
   function automatic int diff_writes();
      int d = got.size() > exp_q.size() ? got.size() - exp_q.size() : exp_q.size() - got.size();
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] != exp_q[i]) d++;
      return d;
   endfunction
   function automatic int outcome();
      return o_Core_Reset === 1'b0 ? 1 : (o_Error === 1'b1 ? 2 : 0);
   endfunction
   task automatic send_byte(input bit [7:0] b, input int gap);
      repeat (gap) @(negedge i_Clock);
      i_Rx_DV = 1'b1;
      i_Rx_Byte = b;
      @(negedge i_Clock);
      i_Rx_DV = 1'b0;
   endtask
   task automatic send_range(input bq_t q, input int from, input int to, input int lo, input int hi);
      for (int i = from; i < to && i < q.size(); i++) send_byte(q[i], int'($urandom_range(lo, hi)));
   endtask
   task automatic wait_busy(input int limit, output int c);
      c = 0;
      while (o_Busy === 1'b1 && c < limit) begin
         @(negedge i_Clock);
         c++;
      end
   endtask
   task automatic wait_req(input int limit, output int c);
      c = 0;
      while (o_Mem_Req === 1'b1 && c < limit) begin
         @(negedge i_Clock);
         c++;
      end
   endtask
   task automatic do_reset;
      i_Reset = 1'b1;
      i_Rx_DV = 1'b0;
      repeat (2) @(negedge i_Clock);
      i_Reset = 1'b0;
      got.delete();
      req_seen = 0;
      stab_err = 0;
      @(negedge i_Clock);
   endtask
   task automatic test_reset;
      i_Reset = 1'b0;
      #2 i_Reset = 1'b1;
      #1;
      checks++;
      if ({o_Mem_Req, o_Mem_Addr, o_Mem_Data} !== 65'h0) begin
         errors++;
         $display("FAIL reset_mem: req/addr/data %h, required 0", {o_Mem_Req, o_Mem_Addr, o_Mem_Data});
      end
      checks++;
      if ({o_Core_Reset, o_Busy, o_Error} !== 3'b100) begin
         errors++;
         $display("FAIL reset_status: core/busy/err %b, required 100", {o_Core_Reset, o_Busy, o_Error});
      end
      do_reset();
   endtask
   task automatic test_spec_frame;
      bq_t f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      do_reset();
      send_range(f, 0, f.size() - 1, 3, 3);
      repeat (10) @(negedge i_Clock);
      checks++;
      if ({o_Core_Reset, o_Busy} !== 2'b11) begin
         errors++;
         $display("FAIL spec_pre_csum: core/busy %b, required 11", {o_Core_Reset, o_Busy});
      end
      send_byte(f[f.size()-1], 3);
      checks++;
      if ({o_Core_Reset, o_Busy, o_Error} !== 3'b000) begin
         errors++;
         $display("FAIL spec_done: core/busy/err %b, required 000", {o_Core_Reset, o_Busy, o_Error});
      end
      checks++;
      if (got.size() != 2 || got[0] !== 64'h00001000_44332211 || got[1] !== 64'h00001004_88776655) begin
         errors++;
         $display("FAIL spec_writes: %0d writes first %h, required 2 writes 0000100044332211/0000100488776655",
                  got.size(), got.size() > 0 ? got[0] : 64'h0);
      end
      send_range(make_frame(32'h2000, 1, 1'b1), 0, 14, 3, 6);
      repeat (10) @(negedge i_Clock);
      checks++;
      if (got.size() != 2 || o_Core_Reset !== 1'b0) begin
         errors++;
         $display("FAIL done_ignores: %0d writes core_reset %b, required 2 writes core_reset 0", got.size(), o_Core_Reset);
      end
   endtask
   task automatic test_back_to_back;
      bq_t f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      int c, e;
      do_reset();
      send_range(f, 0, f.size(), 3, 8);
      checks++;
      if ({o_Core_Reset, o_Error, got.size()} !== {2'b11, 32'd2}) begin
         errors++;
         $display("FAIL bad_csum: core/err %b writes %0d, required 11 and 2", {o_Core_Reset, o_Error}, got.size());
      end
      got.delete();
      f = make_frame(32'h3000, 2, 1'b1);
      e = model(f);
      send_range(f, 0, f.size(), 6, 12);
      wait_busy(200, c);
      checks++;
      if (outcome() != e || diff_writes() != 0) begin
         errors++;
         $display("FAIL recover_after_error: outcome %0d bad writes %0d, required %0d and 0", outcome(), diff_writes(), e);
      end
   endtask
   task automatic test_misaligned;
      bq_t f = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      do_reset();
      send_range(f, 0, 5, 3, 3);
      checks++;
      if (o_Error !== 1'b1) begin
         errors++;
         $display("FAIL misaligned_err: o_Error %b, required 1", o_Error);
      end
      send_range(f, 5, f.size(), 3, 3);
      repeat (5) @(negedge i_Clock);
      checks++;
      if (req_seen !== 1'b0 || o_Core_Reset !== 1'b1) begin
         errors++;
         $display("FAIL misaligned_noreq: req_seen %b core_reset %b, required 0 and 1", req_seen, o_Core_Reset);
      end
   endtask
   task automatic test_random_frames;
      for (int n = 0; n < 8; n++) begin
         bq_t f, g;
         int e, c, len;
         bit [31:0] a;
         do_reset();
         a = n == 0 ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         if (n == 1) a[0] = 1'b1;
         len = n == 0 ? 3 : int'($urandom_range(0, 4));
         f = make_frame(a, len, $urandom_range(0, 3) != 0);
         repeat ($urandom_range(0, 3)) g.push_back(8'($urandom_range(0, 8'hA4)));
         foreach (f[i]) g.push_back(f[i]);
         e = model(g);
         send_range(g, 0, g.size(), 6, 20);
         wait_busy(200, c);
         checks++;
         if (outcome() != e || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_outcome: outcome %0d busy %b, required %0d busy 0", n, outcome(), o_Busy, e);
         end
         checks++;
         if (diff_writes() != 0 || stab_err != 0) begin
            errors++;
            $display("FAIL rand%0d_writes: %0d bad writes %0d unstable cycles, required 0 and 0", n, diff_writes(), stab_err);
         end
      end
   endtask
   task automatic test_len_limit;
      int lens[3] = '{int'(MAXW), int'(MAXW) + 1, 0};
      foreach (lens[k]) begin
         bq_t f;
         int e, c;
         do_reset();
         f = make_frame(32'h0000_8000, lens[k], 1'b1);
         e = model(f);
         send_range(f, 0, f.size(), 6, 12);
         wait_busy(200, c);
         checks++;
         if (outcome() != e || diff_writes() != 0) begin
            errors++;
            $display("FAIL len%0d: outcome %0d bad writes %0d, required %0d and 0", lens[k], outcome(), diff_writes(), e);
         end
      end
   endtask
   task automatic test_overrun;
      bq_t f;
      int e, c;
      do_reset();
      stall = 2000;
      f = make_frame(32'h200, 2, 1'b1);
      e = model(f);
      send_range(f, 0, 15, 2, 2);
      checks++;
      if ({o_Mem_Req, o_Error} !== 2'b10) begin
         errors++;
         $display("FAIL overrun_pending: req/err %b, required 10", {o_Mem_Req, o_Error});
      end
      wait_req(3000, c);
      checks++;
      if (o_Error !== 1'b1 || got.size() != 1 || c >= 3000 || (got.size() > 0 && got[0] !== exp_q[0])) begin
         errors++;
         $display("FAIL overrun_error: err %b writes %0d wait %0d, required err 1 and 1 write", o_Error, got.size(), c);
      end
      do_reset();
      f = make_frame(32'h300, 2, 1'b1);
      e = model(f);
      send_range(f, 0, 14, 2, 2);
      wait_req(3000, c);
      send_range(f, 14, f.size(), 2, 2);
      wait_busy(3000, c);
      checks++;
      if (outcome() != e || diff_writes() != 0 || stab_err != 0) begin
         errors++;
         $display("FAIL skid_one: outcome %0d bad writes %0d unstable %0d, required %0d 0 0", outcome(), diff_writes(), stab_err, e);
      end
      stall = -1;
   endtask
   task automatic test_timeout;
      bq_t f;
      int e, c;
      do_reset();
      send_byte(8'hA5, 3);
      send_byte(8'h00, 3);
      send_byte(8'h01, 3);
      c = 0;
      while (o_Error !== 1'b1 && c < 300) begin
         @(negedge i_Clock);
         c++;
      end
      checks++;
      if (c != int'(TO)) begin
         errors++;
         $display("FAIL timeout_cycles: error after %0d cycles, required %0d", c, TO);
      end
      f = make_frame(32'h100, 1, 1'b1);
      e = model(f);
      send_byte(f[0], 3);
      checks++;
      if ({o_Error, o_Busy} !== 2'b01) begin
         errors++;
         $display("FAIL timeout_clear: err/busy %b, required 01", {o_Error, o_Busy});
      end
      send_range(f, 1, f.size(), 3, 10);
      wait_busy(200, c);
      checks++;
      if (outcome() != e || diff_writes() != 0) begin
         errors++;
         $display("FAIL timeout_reload: outcome %0d bad writes %0d, required %0d and 0", outcome(), diff_writes(), e);
      end
   endtask
   task automatic test_reset_mid_data;
      do_reset();
      stall = 2000;
      send_range(make_frame(32'h400, 2, 1'b1), 0, 13, 2, 2);
      repeat (3) @(negedge i_Clock);
      checks++;
      if (o_Mem_Req !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: req %b, required 1", o_Mem_Req);
      end
      i_Reset = 1'b1;
      #1;
      checks++;
      if ({o_Mem_Req, o_Busy, o_Core_Reset, o_Error} !== 4'b0010) begin
         errors++;
         $display("FAIL midreset: req/busy/core/err %b, required 0010", {o_Mem_Req, o_Busy, o_Core_Reset, o_Error});
      end
      @(negedge i_Clock);
      i_Reset = 1'b0;
      stall = -1;
   endtask
   initial begin
      test_reset();
      test_spec_frame();
      test_back_to_back();
      test_misaligned();
      test_random_frames();
      test_len_limit();
      test_overrun();
      test_timeout();
      test_reset_mid_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
